// File: rtl/switch_allocator_if.sv
// Request/grant bundle between input ports, switch allocator and crossbar.
// Carries perf_conflict_o only when SA_PERF_CNT_EN is defined.
interface switch_allocator_if #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
);
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PW = $clog2(PORT_NUM);

  logic [PORT_NUM-1:0][VC_NUM-1:0]         switch_request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         on_off_i;
  logic [PORT_NUM-1:0][VW-1:0]             vc_sel_o;
  logic [PORT_NUM-1:0]                     valid_sel_o;
  logic [PORT_NUM-1:0][PW-1:0]             xb_sel_o;
  logic [PORT_NUM-1:0]                     xb_valid_o;
  logic                                    error_o;
`ifdef SA_PERF_CNT_EN
  logic [PORT_NUM-1:0][15:0]               perf_conflict_o;

  modport master (
    output switch_request_i, out_port_i,
    output downstream_vc_i, on_off_i,
    input  vc_sel_o, valid_sel_o,
    input  xb_sel_o, xb_valid_o,
    input  error_o, perf_conflict_o
  );

  modport slave (
    input  switch_request_i, out_port_i,
    input  downstream_vc_i, on_off_i,
    output vc_sel_o, valid_sel_o,
    output xb_sel_o, xb_valid_o,
    output error_o, perf_conflict_o
  );
`else
  modport master (
    output switch_request_i, out_port_i,
    output downstream_vc_i, on_off_i,
    input  vc_sel_o, valid_sel_o,
    input  xb_sel_o, xb_valid_o,
    input  error_o
  );

  modport slave (
    input  switch_request_i, out_port_i,
    input  downstream_vc_i, on_off_i,
    output vc_sel_o, valid_sel_o,
    output xb_sel_o, xb_valid_o,
    output error_o
  );
`endif
endinterface

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator.
// SA_PERF_CNT_EN adds per-output saturating conflict counters.
module switch_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2
) (
  input logic              clk,
  input logic              rst,
  switch_allocator_if.slave sa
);
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PW = $clog2(PORT_NUM);

  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_q;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] port_q;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] dvc_q;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         onoff_q;

  logic [PORT_NUM-1:0][VW-1:0] in_ptr;
  logic [PORT_NUM-1:0][PW-1:0] out_ptr;

  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic                            err_now;
  logic [PORT_NUM-1:0]             cand_vld;
  logic [PORT_NUM-1:0][VW-1:0]     cand;
  logic [PORT_NUM-1:0][PW-1:0]     cand_port;
  logic [PORT_NUM-1:0]             win_vld;
  logic [PORT_NUM-1:0][PW-1:0]     win;
  logic [PORT_NUM-1:0]             conflict;
  logic [PORT_NUM-1:0]             gnt_in;

  logic [PORT_NUM-1:0][VW-1:0] vc_sel_q;
  logic [PORT_NUM-1:0]         valid_q;
  logic [PORT_NUM-1:0][PW-1:0] xb_sel_q;
  logic [PORT_NUM-1:0]         xb_valid_q;
  logic                        err_q;

  function automatic logic [VW-1:0] vc_add(
    input logic [VW-1:0] a, input int k
  );
    return VW'((int'(a) + k) % VC_NUM);
  endfunction

  function automatic logic [PW-1:0] port_add(
    input logic [PW-1:0] a, input int k
  );
    return PW'((int'(a) + k) % PORT_NUM);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      port_q  <= '0;
      dvc_q   <= '0;
      onoff_q <= '0;
    end else begin
      req_q   <= sa.switch_request_i;
      port_q  <= sa.out_port_i;
      dvc_q   <= sa.downstream_vc_i;
      onoff_q <= sa.on_off_i;
    end
  end

  // Out-of-range ports are flagged and never index the on/off table.
  always_comb begin
    elig    = '0;
    err_now = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (req_q[i][v]) begin
          if (int'(port_q[i][v]) >= PORT_NUM)
            err_now = 1'b1;
          else
            elig[i][v] = onoff_q[port_q[i][v]][dvc_q[i][v]];
        end
      end
    end
  end

  always_comb begin
    cand_vld  = '0;
    cand      = '0;
    cand_port = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        if (!cand_vld[i] && elig[i][vc_add(in_ptr[i], k)]) begin
          cand_vld[i] = 1'b1;
          cand[i]     = vc_add(in_ptr[i], k);
        end
      end
      cand_port[i] = port_q[i][cand[i]];
    end
  end

  always_comb begin
    win_vld  = '0;
    win      = '0;
    conflict = '0;
    gnt_in   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        if (cand_vld[port_add(out_ptr[o], k)] &&
            cand_port[port_add(out_ptr[o], k)] == PW'(o)) begin
          if (win_vld[o]) begin
            conflict[o] = 1'b1;
          end else begin
            win_vld[o] = 1'b1;
            win[o]     = port_add(out_ptr[o], k);
          end
        end
      end
    end
    for (int i = 0; i < PORT_NUM; i++)
      for (int o = 0; o < PORT_NUM; o++)
        if (win_vld[o] && win[o] == PW'(i))
          gnt_in[i] = 1'b1;
  end

  // Losing inputs keep their VC pointer so they retry the same VC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ptr     <= '0;
      out_ptr    <= '0;
      vc_sel_q   <= '0;
      valid_q    <= '0;
      xb_sel_q   <= '0;
      xb_valid_q <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= gnt_in;
      xb_valid_q <= win_vld;
      if (err_now)
        err_q <= 1'b1;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (gnt_in[i]) begin
          vc_sel_q[i] <= cand[i];
          in_ptr[i]   <= vc_add(cand[i], 1);
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (win_vld[o]) begin
          xb_sel_q[o] <= win[o];
          out_ptr[o]  <= port_add(win[o], 1);
        end
      end
    end
  end

  assign sa.vc_sel_o    = vc_sel_q;
  assign sa.valid_sel_o = valid_q;
  assign sa.xb_sel_o    = xb_sel_q;
  assign sa.xb_valid_o  = xb_valid_q;
  assign sa.error_o     = err_q;

`ifdef SA_PERF_CNT_EN
  logic [PORT_NUM-1:0][15:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++)
        if (conflict[o] && perf_q[o] != 16'hFFFF)
          perf_q[o] <= perf_q[o] + 16'd1;
    end
  end

  assign sa.perf_conflict_o = perf_q;
`endif
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, latency,
// rotation, flow control, parallel grants and sticky error.
module tb_switch_allocator;
  localparam int PN = 5;
  localparam int VN = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  switch_allocator_if #(.PORT_NUM(PN), .VC_NUM(VN)) sa ();

  switch_allocator #(.PORT_NUM(PN), .VC_NUM(VN)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    sa.switch_request_i = '0;
    sa.out_port_i       = '0;
    sa.downstream_vc_i  = '0;
    sa.on_off_i         = '1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    tick();
    clear();
    rst = 1'b1;
    tick();
  endtask

  task automatic req(
    input int i, input int v, input int p, input int d
  );
    sa.switch_request_i[i][v] = 1'b1;
    sa.out_port_i[i][v]       = 3'(p);
    sa.downstream_vc_i[i][v]  = 1'(d);
  endtask

  initial begin
    int seq_in [4];
    int seq_vc [3];
    seq_in = '{0, 2, 4, 0};
    seq_vc = '{0, 1, 0};
    n_chk  = 0;
    n_fail = 0;
    clear();
    rst = 1'b0;

    // requests driven while in reset
    req(1, 1, 3, 0);
    tick();
    tick();
    chk("rst_valid_sel", 32'(sa.valid_sel_o), 0);
    chk("rst_xb_valid", 32'(sa.xb_valid_o), 0);
    chk("rst_vc_sel", 32'(sa.vc_sel_o), 0);
    chk("rst_xb_sel", 32'(sa.xb_sel_o), 0);
    chk("rst_error", 32'(sa.error_o), 0);

    rst = 1'b1;
    tick();
    chk("first_edge_no_grant", 32'(sa.valid_sel_o), 0);
    tick();
    chk("single_valid_sel", 32'(sa.valid_sel_o), 32'h02);
    chk("single_vc_sel1", 32'(sa.vc_sel_o[1]), 1);
    chk("single_xb_valid", 32'(sa.xb_valid_o), 32'h08);
    chk("single_xb_sel3", 32'(sa.xb_sel_o[3]), 1);
    clear();
    tick();
    tick();
    chk("idle_valid_sel", 32'(sa.valid_sel_o), 0);
    chk("idle_xb_valid", 32'(sa.xb_valid_o), 0);
    chk("idle_hold_xb_sel3", 32'(sa.xb_sel_o[3]), 1);
    chk("idle_hold_vc_sel1", 32'(sa.vc_sel_o[1]), 1);

    // three inputs contend for output 1
    do_reset();
    req(0, 0, 1, 0);
    req(2, 0, 1, 0);
    req(4, 0, 1, 0);
    tick();
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("cont_valid_sel_%0d", g),
          32'(sa.valid_sel_o), 32'(1) << seq_in[g]);
      chk($sformatf("cont_xb_valid_%0d", g),
          32'(sa.xb_valid_o), 32'h02);
      chk($sformatf("cont_xb_sel1_%0d", g),
          32'(sa.xb_sel_o[1]), 32'(seq_in[g]));
    end

    // asynchronous reset clears outputs before any edge
    rst = 1'b0;
    #1;
    chk("async_rst_valid_sel", 32'(sa.valid_sel_o), 0);
    chk("async_rst_xb_valid", 32'(sa.xb_valid_o), 0);
    chk("async_rst_xb_sel1", 32'(sa.xb_sel_o[1]), 0);

    // two VCs of input 2 to output 0
    do_reset();
    req(2, 0, 0, 0);
    req(2, 1, 0, 1);
    tick();
    for (int g = 0; g < 3; g++) begin
      tick();
      chk($sformatf("vcrot_valid_sel_%0d", g),
          32'(sa.valid_sel_o), 32'h04);
      chk($sformatf("vcrot_vc_sel2_%0d", g),
          32'(sa.vc_sel_o[2]), 32'(seq_vc[g]));
      chk($sformatf("vcrot_xb_sel0_%0d", g),
          32'(sa.xb_sel_o[0]), 2);
    end

    // downstream VC off blocks the request
    do_reset();
    sa.on_off_i[3][0] = 1'b0;
    req(0, 0, 3, 0);
    tick();
    tick();
    tick();
    chk("fc_off_valid_sel", 32'(sa.valid_sel_o), 0);
    chk("fc_off_xb_valid", 32'(sa.xb_valid_o), 0);
    sa.on_off_i[3][0] = 1'b1;
    tick();
    chk("fc_on_latency", 32'(sa.valid_sel_o), 0);
    tick();
    chk("fc_on_valid_sel", 32'(sa.valid_sel_o), 32'h01);
    chk("fc_on_xb_valid", 32'(sa.xb_valid_o), 32'h08);
    chk("fc_on_xb_sel3", 32'(sa.xb_sel_o[3]), 0);

    // five inputs to five distinct outputs
    do_reset();
    for (int i = 0; i < PN; i++)
      req(i, 0, (i + 2) % PN, 0);
    tick();
    tick();
    chk("par_valid_sel", 32'(sa.valid_sel_o), 32'h1F);
    chk("par_xb_valid", 32'(sa.xb_valid_o), 32'h1F);
    for (int o = 0; o < PN; o++)
      chk($sformatf("par_xb_sel%0d", o),
          32'(sa.xb_sel_o[o]), 32'((o + 3) % PN));

    // illegal out_port on a requesting VC
    do_reset();
    req(0, 0, 7, 0);
    req(1, 0, 4, 0);
    tick();
    tick();
    chk("err_valid_sel", 32'(sa.valid_sel_o), 32'h02);
    chk("err_xb_valid", 32'(sa.xb_valid_o), 32'h10);
    chk("err_flag", 32'(sa.error_o), 1);
    clear();
    tick();
    tick();
    tick();
    chk("err_sticky", 32'(sa.error_o), 1);
    chk("err_idle_valid_sel", 32'(sa.valid_sel_o), 0);
    do_reset();
    chk("err_cleared", 32'(sa.error_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
